// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver: two-flop synchronizer, mid-bit sampling FSM and a show-ahead output FIFO.
// Good bytes are pushed on the stop-bit sample edge; bad stop bits and full-FIFO drops pulse flags.
module uart_rx_fifo #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned CW           = $clog2(FIFO_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          rx,
  output logic [7:0]    m_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [CW-1:0] fifo_count,
  output logic          busy,
  output logic          frame_err,
  output logic          overrun
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam logic [CntW-1:0] HalfMax = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0] FullMax = CntW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

  logic            rx_meta_q, rx_s_q;
  state_e          state_q;
  logic [CntW-1:0] clk_cnt_q;
  logic [2:0]      bit_cnt_q;
  logic [7:0]      shift_q;
  logic            frame_err_q;

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            overrun_q;

  logic half_hit, full_hit, push, pop, full, do_push;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  assign half_hit = (clk_cnt_q == HalfMax);
  assign full_hit = (clk_cnt_q == FullMax);
  // Push is decoded from the stop-bit sample itself so the byte lands on that same edge.
  assign push     = (state_q == StStop) && full_hit && rx_s_q;
  assign pop      = m_valid && m_ready;
  assign full     = (count_q == CW'(FIFO_DEPTH));
  assign do_push  = push && (!full || pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      clk_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (!rx_s_q) begin
            state_q   <= StStart;
            clk_cnt_q <= '0;
          end
        end
        StStart: begin
          if (half_hit) begin
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            state_q   <= rx_s_q ? StIdle : StData;
          end else begin
            clk_cnt_q <= clk_cnt_q + CntW'(1);
          end
        end
        StData: begin
          if (full_hit) begin
            clk_cnt_q <= '0;
            shift_q   <= {rx_s_q, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_q <= StStop;
          end else begin
            clk_cnt_q <= clk_cnt_q + CntW'(1);
          end
        end
        StStop: begin
          if (full_hit) begin
            clk_cnt_q <= '0;
            if (rx_s_q) begin
              state_q <= StIdle;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= StBreak;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + CntW'(1);
          end
        end
        StBreak: begin
          // Hold off until the line returns high so a stuck-low line cannot retrigger.
          if (rx_s_q) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= push && !do_push;
      if (do_push) begin
        mem_q[wr_ptr_q] <= shift_q;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      unique case ({do_push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign m_data     = mem_q[rd_ptr_q];
  assign m_valid    = (count_q != '0);
  assign fifo_count = count_q;
  assign busy       = (state_q != StIdle);
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- UART 8N1 receiver with an output FIFO.
- Counterpart to the AXI-to-FIFO-to-UART transmit path: it consumes the serial `tx` line produced by that path and returns received bytes on a valid/ready stream.
- Used as the loopback checker on the board and as the receive half of the UART peripheral.
- Oversamples `rx` with the system clock, samples each bit at mid-bit, checks the stop bit, and buffers good bytes in a show-ahead FIFO.

Parameters:
- CLKS_PER_BIT, 868, system clocks per UART bit; minimum 4.
- FIFO_DEPTH, 8, FIFO entries; power of two, at least 2.
- CW, $clog2(FIFO_DEPTH+1), width of `fifo_count`; derived, not overridden.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- rx  input  1  serial line; idles high; asynchronous to `clk`.
- m_data  output  8  head-of-FIFO byte; valid while `m_valid` is 1.
- m_valid  output  1  FIFO not empty.
- m_ready  input  1  consumer accept; a pop occurs when `m_valid` and `m_ready` are both 1.
- fifo_count  output  CW  number of stored bytes.
- busy  output  1  receiver FSM is not in IDLE.
- frame_err  output  1  one-cycle pulse when a stop bit is sampled as 0.
- overrun  output  1  one-cycle pulse when a good byte is dropped because the FIFO is full.

Behaviour:

Reset (`reset` = 0):
- FSM goes to IDLE; bit counter and clock counter clear to 0.
- The two synchronizer flops are set to 1.
- FIFO pointers and count clear to 0.
- All outputs are 0: `m_data` = 0x00, `m_valid` = 0, `busy` = 0, `frame_err` = 0, `overrun` = 0, `fifo_count` = 0.
- Reset mid-frame abandons the partial byte with no pulses.
- Release from reset takes effect on the next `clk` edge.

Input synchronizer:
- `rx` passes through two flops; the FSM uses only the second flop, `rx_s`.
- Latency from `rx` to `rx_s` is 2 cycles.

FSM states:
- IDLE: when `rx_s` = 0, go to START and clear the clock counter.
- START: count to CLKS_PER_BIT/2 - 1 (integer division), then sample `rx_s`.
  - If the sample is 0, go to DATA and clear the counters.
  - If the sample is 1, treat it as a glitch: return to IDLE with no pulse.
- DATA: count to CLKS_PER_BIT - 1, then sample `rx_s` into the shift register, LSB first.
  - After bit index 7 is sampled, go to STOP.
- STOP: count to CLKS_PER_BIT - 1, then sample `rx_s`.
  - If the sample is 1, push the byte to the FIFO and go to IDLE.
  - If the sample is 0, pulse `frame_err` for one cycle, discard the byte, and go to BREAK.
- BREAK: wait until `rx_s` = 1, then go to IDLE. This prevents retriggering on a held-low line.

Status and timing:
- `busy` = 1 in START, DATA, STOP and BREAK.
- Receive latency: `m_valid` and the updated `fifo_count` appear on the cycle after the stop-bit sample edge.

FIFO:
- Show-ahead: `m_data` always presents the entry at the read pointer.
- Read and write pointers wrap modulo FIFO_DEPTH.
- Push with FIFO not full: write the byte and increment `fifo_count`.
- Push with FIFO full and a pop in the same cycle: both happen and `fifo_count` is unchanged.
- Push with FIFO full and no pop: drop the byte and pulse `overrun` for one cycle; stored data is unchanged.
- Pop with FIFO empty: ignored.
- Push and pop together when not full or empty: `fifo_count` is unchanged.
- `m_data` holds its last value when the FIFO is empty; this value is don't-care for checking.

Test Plan (CLKS_PER_BIT = 16, FIFO_DEPTH = 4, `m_ready` = 0 unless stated):
- Drive one 8N1 frame of 0xA5 on `rx` at 16 clocks per bit.
  -> `m_valid` = 1, `m_data` = 0xA5, `fifo_count` = 1, no pulses.
  -> Then set `m_ready` = 1 for one cycle: `m_valid` = 0, `fifo_count` = 0.
- Send frames 0x00, 0xFF, 0x3C back-to-back with no idle gap.
  -> `fifo_count` = 3.
  -> Popping with `m_ready` = 1 yields 0x00, 0xFF, 0x3C in order.
- Pull `rx` low for 4 clocks, then return it high.
  -> `busy` goes high, then returns to 0 within 10 cycles.
  -> No push, no `frame_err`.
- Send 0x55 with stop bit = 0, then hold `rx` low for 40 clocks, then high.
  -> Exactly one `frame_err` pulse, `fifo_count` stays 0.
  -> A following frame of 0x12 is received correctly.
- Send 5 frames 0x01 to 0x05 with no pops.
  -> `fifo_count` = 4, exactly one `overrun` pulse, on frame 5.
  -> Pops yield 0x01 to 0x04.
  -> Repeat with `m_ready` = 1 held during the 5th stop-bit sample: no `overrun`, and 0x05 is retained.
- Assert `reset` low during bit 3 of a 0xC3 frame.
  -> All outputs are 0 immediately.
  -> After release and an idle line, a 0x7E frame is received with `fifo_count` = 1.
